alu_serial_seq: RTL

Bit-serial ALU controller. Accepts one WIDTH-bit operation via a valid/ready handshake and sequences a single 1-bit ALU slice (a/b invert, and, or, full-add, set/less) over WIDTH cycles, LSB first. It holds the carry chain, steers the invert controls, and resolves set-less-than at the MSB. The result is returned through a second valid/ready handshake. Used where area matters more than latency.

---
 rtl/alu_serial_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU controller: drives a 1-bit ALU slice LSB-first over WIDTH cycles.
// Operands are latched on accept; results and flags are returned through a valid/ready handshake.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             err,
    output logic             busy
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [3:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             c_q, cout_q, ovf_q, err_q, zero_q, out_valid_q;

    // One bit of the ALU slice, evaluated at the current index
    logic s_bit, t_bit, sum_bit, c_next, slice_bit;
    logic legal, arith, is_slt, last;

    always_comb begin
        s_bit   = a_q[idx_q] ^ op_q[3];
        t_bit   = b_q[idx_q] ^ op_q[2];
        sum_bit = s_bit ^ t_bit ^ c_q;
        c_next  = (s_bit & t_bit) | (s_bit & c_q) | (t_bit & c_q);
        case (op_q[1:0])
            2'b00:   slice_bit = s_bit & t_bit;
            2'b01:   slice_bit = s_bit | t_bit;
            2'b10:   slice_bit = sum_bit;
            default: slice_bit = 1'b0;
        endcase
        legal  = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) ||
                 (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_NOR);
        arith  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
        is_slt = (op_q == OP_SLT);
        last   = (idx_q == IW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            idx_q       <= '0;
            c_q         <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        res_q   <= '0;
                        idx_q   <= '0;
                        c_q     <= (op == OP_SUB) || (op == OP_SLT);
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b0;
                        zero_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[idx_q] <= slice_bit;
                    c_q          <= c_next;
                    if (last) begin
                        state_q <= DONE;
                        // Later assignments to res_q override the per-bit write above
                        if (!legal) begin
                            res_q <= '0;
                            err_q <= 1'b1;
                        end else if (is_slt) begin
                            res_q  <= {{(WIDTH-1){1'b0}}, sum_bit ^ (c_q ^ c_next)};
                            cout_q <= c_next;
                        end else if (arith) begin
                            cout_q <= c_next;
                            ovf_q  <= c_q ^ c_next;
                        end
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle settles zero from the final result, then raises out_valid
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        zero_q      <= (res_q == '0);
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign err       = err_q;
endmodule
